// File: rtl/popcount_pkg.sv
// Shared types and helpers for the multi-cycle popcount block.
// Used by chunk_popcount and popcount_seq.
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;

  // Width needed to hold a count from 0 to w.
  function automatic int cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational popcount of a K-bit slice.
module chunk_popcount #(
  parameter int K = 4,
  localparam int PW = $clog2(K + 1)
) (
  input  logic [K-1:0]  bits,
  output logic [PW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < K; i++) count = count + PW'(bits[i]);
  end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle ones/zeros counter, K bits per cycle, ready/valid on both sides.
// Define POPCOUNT_EARLY_EXIT_EN to finish as soon as the remaining bits are all zero.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int W = 32,
  parameter int K = 4,
  localparam int CW = cw(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count
);

  localparam int N   = W / K;
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = $clog2(K + 1);

  if (K < 1 || K > W || (W % K) != 0) begin : g_bad_cfg
    $error("popcount_seq: need 1 <= K <= W and W %% K == 0");
  end

  pc_state_t      state;
  logic [W-1:0]   sreg, sreg_sh;
  logic [CHW-1:0] chunk;
  logic [CW-1:0]  acc, acc_nxt;
  logic [PW-1:0]  pc;
  logic           last;

  chunk_popcount #(.K(K)) u_chunk (.bits(sreg[K-1:0]), .count(pc));

  // With K == W the whole word is consumed in one step; nothing is left to shift.
  if (K < W) begin : g_shift
    assign sreg_sh = {{K{1'b0}}, sreg[W-1:K]};
  end else begin : g_noshift
    assign sreg_sh = '0;
  end

  assign acc_nxt = acc + CW'(pc);

`ifdef POPCOUNT_EARLY_EXIT_EN
  assign last = (chunk == CHW'(N - 1)) || (sreg_sh == '0);
`else
  assign last = (chunk == CHW'(N - 1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      sreg      <= '0;
      chunk     <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          // Zeros mode is inverted here so RUN only ever counts ones.
          sreg     <= mode ? ~in_data : in_data;
          acc      <= '0;
          chunk    <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          acc  <= acc_nxt;
          sreg <= sreg_sh;
          if (last) begin
            out_count <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: W=32/K=4 main instance plus W=30/K=1 legacy instance.
module tb_popcount_seq;

`ifdef POPCOUNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        in_valid, in_ready, mode, out_valid, out_ready;
  logic [31:0] in_data;
  logic [5:0]  out_count;

  logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
  logic [29:0] b_in_data;
  logic [4:0]  b_out_count;

  popcount_seq #(.W(32), .K(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  popcount_seq #(.W(30), .K(1)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count)
  );

  typedef struct {
    int cnt;
    int t0;
    int lat;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the 32-bit instance.
  int   rise_a = 0;
  bit   pv_a = 1'b0;
  exp_t ea;
  always @(negedge clock) begin
    if (out_valid && !pv_a) rise_a = cyc;
    pv_a = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("a_unexpected_result", 1, 0);
      else begin
        ea = q.pop_front();
        check("a_count", int'(out_count), ea.cnt);
        if (ea.lat > 0) check("a_latency", rise_a - ea.t0, ea.lat);
      end
    end
  end

  // Monitor for the legacy 30-bit instance.
  int   rise_b = 0;
  bit   pv_b = 1'b0;
  exp_t eb;
  always @(negedge clock) begin
    if (b_out_valid && !pv_b) rise_b = cyc;
    pv_b = b_out_valid;
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check("b_unexpected_result", 1, 0);
      else begin
        eb = qb.pop_front();
        check("b_count", int'(b_out_count), eb.cnt);
        if (eb.lat > 0) check("b_latency", rise_b - eb.t0, eb.lat);
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic m, input int cnt, input int lat,
                        input bit keep);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (!in_ready) begin check("a_in_ready_timeout", 0, 1); return; end
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clock); #1;
    e.cnt = cnt; e.t0 = cyc; e.lat = lat;
    q.push_back(e);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [29:0] d, input logic m, input int cnt, input int lat);
    exp_t e;
    int n = 0;
    while (!b_in_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (!b_in_ready) begin check("b_in_ready_timeout", 0, 1); return; end
    b_in_data  = d;
    b_mode     = m;
    b_in_valid = 1'b1;
    @(posedge clock); #1;
    e.cnt = cnt; e.t0 = cyc; e.lat = lat;
    qb.push_back(e);
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || qb.size() != 0) && n < 500) begin @(posedge clock); n++; end
    #1;
    check("drain_pending", q.size() + qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_mode = 1'b0; b_out_ready = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_count", int'(out_count), 0);
    @(negedge clock); reset = 1'b0;
    repeat (2) @(posedge clock); #1;

    // Basic counts: all ones, zeros mode, mixed pattern.
    send_a(32'hFFFF_FFFF, 1'b0, 32, 8, 1'b0);
    drain();
    send_a(32'h0000_00F0, 1'b1, 28, 8, 1'b0);
    send_a(32'hA5A5_0001, 1'b0, 9, 8, 1'b0);
    drain();

    // Consumer stall in DONE; an in_valid pulse meanwhile must be ignored.
    out_ready = 1'b0;
    send_a(32'hFFFF_0000, 1'b0, 16, 8, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clock); n++; end
      check("stall_reach_done", int'(out_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      in_valid = (i == 1);
      in_data  = 32'h0000_00FF;
      @(negedge clock);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_count", int'(out_count), 16);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (12) @(posedge clock);
    @(negedge clock);
    check("stall_pulse_ignored", int'(out_valid), 0);

    // Reset during the third RUN cycle drops the transaction.
    send_a(32'hFFFF_FFFF, 1'b0, 32, 8, 1'b0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrun_rst_out_valid", int'(out_valid), 0);
    check("midrun_rst_in_ready", int'(in_ready), 1);
    check("midrun_rst_out_count", int'(out_count), 0);
    q.delete();
    #1 reset = 1'b0;
    @(posedge clock); #1;
    send_a(32'h0000_0003, 1'b0, 2, EE ? 1 : 8, 1'b0);
    drain();

    // Early-exit candidates: latency 1 with the feature, 8 without.
    send_a(32'h0000_000F, 1'b0, 4, EE ? 1 : 8, 1'b0);
    drain();
    send_a(32'h0000_0000, 1'b0, 0, EE ? 1 : 8, 1'b0);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    send_a(32'h1234_5678, 1'b0, 13, 0, 1'b1);
    send_a(32'h8000_0000, 1'b0, 1, 0, 1'b1);
    send_a(32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
    drain();

    // Legacy configuration W=30, K=1.
    send_b(30'h3FFF_FFFF, 1'b0, 30, 30);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
